// File: rtl/led_key_ctrl.sv
// Key-driven LED mode controller: synchronise and debounce the active-low key, then cycle OFF/ON/SLOW/FAST.
// Optional long-press return-to-OFF is enabled by defining LED_KEY_CTRL_LONG_PRESS_EN.
module led_key_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned SLOW_HALF    = 25_000_000,
  parameter int unsigned FAST_HALF    = 6_250_000,
  parameter int unsigned LONG_CNT     = 100_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  output logic       led,
  output logic [1:0] mode,
  output logic       key_flag,
  output logic       long_flag
);

  localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CNT);
  localparam int unsigned BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned BLINK_W   = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  logic               key_s1_q, key_sync_q;
  logic               key_stable_q, key_stable_d, key_stable_dly_q;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               key_flag_q, key_flag_d;
  mode_e              mode_q, mode_d;
  logic               led_q, led_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d, half_m1;
  logic               long_flag_d;

`ifdef LED_KEY_CTRL_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CNT + 1);
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               long_flag_q;
`else
  logic               long_cnt_unused;
  assign long_cnt_unused = ^LONG_CNT;
`endif

  // Debounce: accept key_sync only after it differs from key_stable for DEBOUNCE_CNT cycles.
  always_comb begin
    deb_cnt_d    = deb_cnt_q;
    key_stable_d = key_stable_q;
    if (key_sync_q == key_stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
      key_stable_d = key_sync_q;
      deb_cnt_d    = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  assign key_flag_d = key_stable_dly_q & ~key_stable_q;
  assign half_m1    = (mode_q == MODE_SLOW) ? BLINK_W'(SLOW_HALF - 1) : BLINK_W'(FAST_HALF - 1);

  // Mode sequencing and LED drive; a mode change sets the LED for the new mode on the same edge.
  always_comb begin
    mode_d      = mode_q;
    led_d       = led_q;
    blink_cnt_d = blink_cnt_q;
    long_flag_d = 1'b0;
`ifdef LED_KEY_CTRL_LONG_PRESS_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    if (key_flag_q) begin
      unique case (mode_q)
        MODE_OFF:  mode_d = MODE_ON;
        MODE_ON:   mode_d = MODE_SLOW;
        MODE_SLOW: mode_d = MODE_FAST;
        default:   mode_d = MODE_OFF;
      endcase
    end

`ifdef LED_KEY_CTRL_LONG_PRESS_EN
    if (key_stable_q) begin
      hold_cnt_d = '0;
    end else begin
      if (hold_cnt_q == HOLD_W'(LONG_CNT - 1)) begin
        long_flag_d = 1'b1;
        mode_d      = MODE_OFF;
      end
      if (hold_cnt_q != HOLD_W'(LONG_CNT)) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
`endif

    if (mode_d != mode_q) begin
      blink_cnt_d = '0;
      led_d       = (mode_d != MODE_OFF);
    end else begin
      unique case (mode_q)
        MODE_OFF: led_d = 1'b0;
        MODE_ON:  led_d = 1'b1;
        default: begin
          if (blink_cnt_q == half_m1) begin
            led_d       = ~led_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
        end
      endcase
    end

    if (long_flag_d) begin
      led_d       = 1'b0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1_q         <= 1'b1;
      key_sync_q       <= 1'b1;
      key_stable_q     <= 1'b1;
      key_stable_dly_q <= 1'b1;
      deb_cnt_q        <= '0;
      key_flag_q       <= 1'b0;
      mode_q           <= MODE_OFF;
      led_q            <= 1'b0;
      blink_cnt_q      <= '0;
    end else begin
      key_s1_q         <= key;
      key_sync_q       <= key_s1_q;
      key_stable_q     <= key_stable_d;
      key_stable_dly_q <= key_stable_q;
      deb_cnt_q        <= deb_cnt_d;
      key_flag_q       <= key_flag_d;
      mode_q           <= mode_d;
      led_q            <= led_d;
      blink_cnt_q      <= blink_cnt_d;
    end
  end

`ifdef LED_KEY_CTRL_LONG_PRESS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
    end
  end
  assign long_flag = long_flag_q;
`else
  assign long_flag = 1'b0;
  logic long_flag_unused;
  assign long_flag_unused = long_flag_d;
`endif

  assign led      = led_q;
  assign mode     = mode_q;
  assign key_flag = key_flag_q;

endmodule

// File: tb/tb_led_key_ctrl.sv
// Bench for led_key_ctrl: directed and random key patterns checked every cycle against a history-based model.
module tb_led_key_ctrl;
  localparam int unsigned DEB = 4;
  localparam int unsigned SH  = 8;
  localparam int unsigned FH  = 2;
  localparam int unsigned LC  = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key;
  logic       led;
  logic [1:0] mode;
  logic       key_flag;
  logic       long_flag;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  led_key_ctrl #(
    .DEBOUNCE_CNT(DEB),
    .SLOW_HALF   (SH),
    .FAST_HALF   (FH),
    .LONG_CNT    (LC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .led      (led),
    .mode     (mode),
    .key_flag (key_flag),
    .long_flag(long_flag)
  );

  // Model state: key samples in flight, window of the last DEB synchronised samples, mode bookkeeping.
  logic       kq[$];
  logic       wq[$];
  logic       m_stable, m_flag, m_long, m_led, fell_prev;
  logic [1:0] m_mode;
  int         hold_age, entry, n_edge;

  task automatic model_reset();
    kq = {1'b1, 1'b1};
    wq.delete();
    repeat (DEB) wq.push_back(1'b1);
    m_stable = 1'b1; m_flag = 1'b0; m_long = 1'b0; m_led = 1'b0; fell_prev = 1'b0;
    m_mode = 2'd0; hold_age = -1; entry = 0; n_edge = 0;
  endtask

  task automatic model_edge(input logic k);
    logic seen, all_diff, adv, fell, prev_stable;
    logic [1:0] new_mode;
    int half;
    seen = kq.pop_front();
    kq.push_back(k);
    void'(wq.pop_front());
    wq.push_back(seen);
    adv    = m_flag;
    m_flag = fell_prev;
    all_diff = 1'b1;
    foreach (wq[i]) if (wq[i] == m_stable) all_diff = 1'b0;
    prev_stable = m_stable;
    fell = all_diff && m_stable;
    if (all_diff) m_stable = ~m_stable;
    fell_prev = fell;
    m_long = 1'b0;
`ifdef LED_KEY_CTRL_LONG_PRESS_EN
    if (!prev_stable && hold_age >= 0) begin
      hold_age++;
      if (hold_age == int'(LC)) m_long = 1'b1;
    end else if (prev_stable) begin
      hold_age = fell ? 0 : -1;
    end
`endif
    new_mode = adv ? m_mode + 2'd1 : m_mode;
    if (m_long) new_mode = 2'd0;
    if (new_mode != m_mode) entry = n_edge;
    m_mode = new_mode;
    case (m_mode)
      2'd0: m_led = 1'b0;
      2'd1: m_led = 1'b1;
      default: begin
        half  = (m_mode == 2'd2) ? int'(SH) : int'(FH);
        m_led = (((n_edge - entry) / half) % 2) == 0;
      end
    endcase
    n_edge++;
  endtask

  task automatic step(input logic k);
    key = k;
    @(posedge sys_clk);
    if (sys_rst_n) model_edge(k);
    else model_reset();
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) step(1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic press(input int lo, input int hi, output logic [1:0] mode_at_end);
    for (int i = 0; i < lo + hi; i++) begin
      step(i < lo ? 1'b0 : 1'b1);
      vectors++;
      if ({led, mode, key_flag, long_flag} !== {m_led, m_mode, m_flag, m_long}) begin
        miscompares++;
        $display("FAIL press i=%0d got led,mode,flag,long=%b want %b", i,
                 {led, mode, key_flag, long_flag}, {m_led, m_mode, m_flag, m_long});
      end
      if (i == lo - 1) mode_at_end = mode;
    end
  endtask

  task automatic test_reset();
    int flags = 0;
    sys_rst_n = 1'b0;
    key = 1'b1;
    model_reset();
    repeat (3) step(1'b1);
    vectors++;
    if ({led, mode, key_flag, long_flag} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_hold got %b want 00000", {led, mode, key_flag, long_flag});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b1);
      flags += int'(key_flag);
      vectors++;
      if ({led, mode, key_flag, long_flag} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_idle i=%0d got %b want 00000", i, {led, mode, key_flag, long_flag});
      end
    end
    vectors++;
    if (flags != 0) begin
      miscompares++;
      $display("FAIL reset_flags got %0d want 0", flags);
    end
  endtask

  task automatic test_bounce();
    logic pat[$] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int flags = 0;
    repeat (12) pat.push_back(1'b1);
    foreach (pat[i]) begin
      step(pat[i]);
      flags += int'(key_flag);
      vectors++;
      if ({led, mode, key_flag, long_flag} !== {m_led, m_mode, m_flag, m_long}) begin
        miscompares++;
        $display("FAIL bounce i=%0d got %b want %b", i,
                 {led, mode, key_flag, long_flag}, {m_led, m_mode, m_flag, m_long});
      end
    end
    vectors++;
    if (flags != 0 || mode !== 2'd0) begin
      miscompares++;
      $display("FAIL bounce_end got flags=%0d mode=%0d want flags=0 mode=0", flags, mode);
    end
  endtask

  task automatic test_press();
    int flags = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      flags += int'(key_flag);
      vectors++;
      if ({led, mode, key_flag, long_flag} !== {m_led, m_mode, m_flag, m_long}) begin
        miscompares++;
        $display("FAIL press_model i=%0d got %b want %b", i,
                 {led, mode, key_flag, long_flag}, {m_led, m_mode, m_flag, m_long});
      end
      if (i == 6 || i == 7) begin
        vectors++;
        if ({mode, led} !== ((i == 7) ? 3'b011 : 3'b000)) begin
          miscompares++;
          $display("FAIL press_latency edge=%0d got mode=%0d led=%b", i, mode, led);
        end
      end
    end
    vectors++;
    if (flags != 1) begin
      miscompares++;
      $display("FAIL press_one_flag got %0d want 1", flags);
    end
    repeat (12) step(1'b1);
  endtask

  task automatic test_full_cycle();
    logic [1:0] seen[4];
    logic [1:0] want[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int p = 0; p < 4; p++) press(20, 20, seen[p]);
    for (int p = 0; p < 4; p++) begin
      vectors++;
      if (seen[p] !== want[p]) begin
        miscompares++;
        $display("FAIL cycle_seq press=%0d got %0d want %0d", p, seen[p], want[p]);
      end
    end
    vectors++;
    if (led !== 1'b0) begin
      miscompares++;
      $display("FAIL cycle_led_off got %b want 0", led);
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [1:0] m;
    do_reset();
    press(20, 20, m);
    press(20, 5, m);
    #3;
    sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({led, mode} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset got led=%b mode=%0d want 0/0", led, mode);
    end
    model_reset();
    step(1'b0);
    step(1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    press(20, 20, m);
    vectors++;
    if (m !== 2'd1) begin
      miscompares++;
      $display("FAIL redebounce got mode=%0d want 1", m);
    end
  endtask

  task automatic test_long_hold();
    logic [1:0] m;
    int longs = 0, long_i = -1;
    do_reset();
    press(20, 20, m);
    press(20, 20, m);
    for (int i = 0; i < 60; i++) begin
      step(1'b0);
      if (long_flag === 1'b1) begin
        longs++;
        long_i = i;
      end
      vectors++;
      if ({led, mode, key_flag, long_flag} !== {m_led, m_mode, m_flag, m_long}) begin
        miscompares++;
        $display("FAIL long_model i=%0d got %b want %b", i,
                 {led, mode, key_flag, long_flag}, {m_led, m_mode, m_flag, m_long});
      end
    end
    vectors++;
`ifdef LED_KEY_CTRL_LONG_PRESS_EN
    if (longs != 1 || long_i != 25 || mode !== 2'd0) begin
      miscompares++;
      $display("FAIL long_end got longs=%0d at=%0d mode=%0d want 1/25/0", longs, long_i, mode);
    end
`else
    if (longs != 0 || mode !== 2'd3) begin
      miscompares++;
      $display("FAIL long_end got longs=%0d mode=%0d want 0/3", longs, mode);
    end
`endif
    repeat (12) step(1'b1);
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int len;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) begin
        step(lvl);
        vectors++;
        if ({led, mode, key_flag, long_flag} !== {m_led, m_mode, m_flag, m_long}) begin
          miscompares++;
          $display("FAIL random seg=%0d i=%0d got %b want %b", s, i,
                   {led, mode, key_flag, long_flag}, {m_led, m_mode, m_flag, m_long});
        end
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_full_cycle();
    test_reset_mid_blink();
    test_long_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
